button_event_scheduler: RTL and testbench

//  Turns N debounced button levels into discrete PRESS/LONG/REPEAT events.

---
 rtl/button_event_scheduler.sv | 234 +++++++++++++++++++++++
 tb/tb_button_event_scheduler.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_scheduler.sv
// -----------------------------------------------------------------------------
// button_event_scheduler
//
// Turns N_BTN debounced button levels into discrete PRESS / LONG / REPEAT
// events and serialises them onto a single valid/ready event stream. Pending
// events are granted round-robin. The stream feeds the clock/alarm setting FSM,
// which consumes one event at a time.
//
// Ports
//   clk        in   1        system clock, all logic on posedge
//   resetn     in   1        synchronous reset, active-low
//   btn_level  in   N_BTN    debounced levels, 1 = pressed
//   evt_valid  out  1        event available
//   evt_ready  in   1        consumer accepts event
//   evt_btn    out  IDX_W    button index of the event
//   evt_kind   out  2        0 PRESS, 1 LONG, 2 REPEAT (3 never produced)
//   evt_drop   out  1        1-cycle pulse: an event was lost because the
//                            button's pending slot was already full
//
// Handshake: an event transfers on a posedge where evt_valid and evt_ready are
// both 1. evt_valid never drops without a transfer, and while evt_valid=1 and
// evt_ready=0 the evt_btn / evt_kind payload is held stable. evt_ready may be
// asserted at any time, independently of evt_valid.
//
// Pipeline: each button FSM registers its emit; the emit lands in that
// button's pending slot one edge later; the arbiter moves a slot into the
// output register one edge after that. A level sampled high at edge t gives
// evt_valid=1 after edge t+2 when the consumer is ready.
// -----------------------------------------------------------------------------
module button_event_scheduler #(
    parameter int N_BTN         = 3,
    parameter int LONG_CYCLES   = 24000000,
    parameter int REPEAT_CYCLES = 4800000,
    parameter int CNT_W         = 25,
    localparam int IDX_W        = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N_BTN-1:0] btn_level,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDX_W-1:0] evt_btn,
    output logic [1:0]       evt_kind,
    output logic             evt_drop
);

    localparam logic [1:0] KIND_PRESS  = 2'd0;
    localparam logic [1:0] KIND_LONG   = 2'd1;
    localparam logic [1:0] KIND_REPEAT = 2'd2;

    // Terminal counts: the counter runs 0..TC, so TC+1 cycles elapse per period.
    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_IDLE = 2'd1,
        ST_HELD = 2'd2,
        ST_RPT  = 2'd3
    } btn_state_t;

    // Per-button emit strobes (registered FSM outputs) and their kinds.
    logic [N_BTN-1:0] emit_v;
    logic [1:0]       emit_k [N_BTN];

    // Pending slots: one entry per button.
    logic [N_BTN-1:0] pend_v;
    logic [1:0]       pend_k [N_BTN];

    // Arbiter signals.
    logic [IDX_W-1:0] rr_q;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] next_rr;
    logic             grant_found;
    logic             load_out;
    logic [N_BTN-1:0] drain_vec;
    logic [N_BTN-1:0] drop_vec;
    int               probe;

    // -------------------------------------------------------------------------
    // Per-button press / long / repeat FSM
    // -------------------------------------------------------------------------
    for (genvar b = 0; b < N_BTN; b++) begin : g_btn
        btn_state_t       state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             emit_q;
        logic [1:0]       kind_q;

        always_ff @(posedge clk) begin
            if (!resetn) begin
                state_q <= ST_ARM;
                cnt_q   <= '0;
                emit_q  <= 1'b0;
                kind_q  <= KIND_PRESS;
            end else begin
                emit_q <= 1'b0;
                case (state_q)
                    // A button held through reset must be released before it
                    // can generate anything.
                    ST_ARM: begin
                        if (!btn_level[b]) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_IDLE: begin
                        if (btn_level[b]) begin
                            emit_q  <= 1'b1;
                            kind_q  <= KIND_PRESS;
                            cnt_q   <= '0;
                            state_q <= ST_HELD;
                        end
                    end
                    // Release is tested first so it beats a same-cycle
                    // terminal count: no LONG/REPEAT on the release cycle.
                    ST_HELD: begin
                        if (!btn_level[b]) begin
                            state_q <= ST_IDLE;
                        end else if (cnt_q == LONG_TC) begin
                            emit_q  <= 1'b1;
                            kind_q  <= KIND_LONG;
                            cnt_q   <= '0;
                            state_q <= ST_RPT;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_RPT: begin
                        if (!btn_level[b]) begin
                            state_q <= ST_IDLE;
                        end else if (cnt_q == REPEAT_TC) begin
                            emit_q <= 1'b1;
                            kind_q <= KIND_REPEAT;
                            cnt_q  <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_ARM;
                    end
                endcase
            end
        end

        assign emit_v[b] = emit_q;
        assign emit_k[b] = kind_q;
    end

    // -------------------------------------------------------------------------
    // Round-robin grant over the pending slots, starting at rr_q
    // -------------------------------------------------------------------------
    assign load_out = !evt_valid || evt_ready;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        probe       = 0;
        for (int i = 0; i < N_BTN; i++) begin
            probe = int'(rr_q) + i;
            if (probe >= N_BTN) begin
                probe = probe - N_BTN;
            end
            if (!grant_found && pend_v[probe[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = probe[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        if (grant_idx == IDX_W'(N_BTN - 1)) begin
            next_rr = '0;
        end else begin
            next_rr = grant_idx + 1'b1;
        end
    end

    // Slot being moved into the output register this cycle.
    always_comb begin
        drain_vec = '0;
        if (load_out && grant_found) begin
            drain_vec[grant_idx] = 1'b1;
        end
    end

    // A new event is lost only if its slot is full and not draining now;
    // a slot that drains in the same cycle accepts the new event.
    assign drop_vec = emit_v & pend_v & ~drain_vec;

    // -------------------------------------------------------------------------
    // Pending slots and drop pulse
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pend_v   <= '0;
            evt_drop <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                pend_k[i] <= KIND_PRESS;
            end
        end else begin
            evt_drop <= |drop_vec;
            for (int i = 0; i < N_BTN; i++) begin
                if (emit_v[i] && !drop_vec[i]) begin
                    pend_v[i] <= 1'b1;
                    pend_k[i] <= emit_k[i];
                end else if (drain_vec[i]) begin
                    pend_v[i] <= 1'b0;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output register and round-robin pointer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            evt_valid <= 1'b0;
            evt_btn   <= '0;
            evt_kind  <= KIND_PRESS;
            rr_q      <= '0;
        end else if (load_out) begin
            if (grant_found) begin
                evt_valid <= 1'b1;
                evt_btn   <= grant_idx;
                evt_kind  <= pend_k[grant_idx];
                rr_q      <= next_rr;
            end else begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_button_event_scheduler.sv
// -----------------------------------------------------------------------------
// Bench for button_event_scheduler (N_BTN=3, LONG=16, REPEAT=8).
// A reference model based on hold age runs every cycle and is compared against
// the DUT outputs; directed tables and sequences cover the named corner cases,
// followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_button_event_scheduler;

    localparam int N      = 3;
    localparam int LONG   = 16;
    localparam int RPT    = 8;
    localparam int CW     = 5;
    localparam int IW     = 2;

    logic          clk;
    logic          resetn;
    logic [N-1:0]  btn_level;
    logic          evt_valid;
    logic          evt_ready;
    logic [IW-1:0] evt_btn;
    logic [1:0]    evt_kind;
    logic          evt_drop;

    button_event_scheduler #(
        .N_BTN(N), .LONG_CYCLES(LONG), .REPEAT_CYCLES(RPT), .CNT_W(CW)
    ) dut (
        .clk(clk), .resetn(resetn), .btn_level(btn_level),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_btn(evt_btn), .evt_kind(evt_kind), .evt_drop(evt_drop)
    );

    // ---------------------------------------------------------------- clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ----------------------------------------------------------- bookkeeping
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int c;
        int b;
        int k;
    } ev_t;
    ev_t ev_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------ reference model
    // Each button is described by how many sampled cycles it has been held:
    // PRESS at age 0, LONG at age LONG, REPEAT every RPT cycles after that.
    int         m_age     [N];
    bit         m_blocked [N];
    bit         m_pipe_v  [N];
    logic [1:0] m_pipe_k  [N];
    bit         m_pend_v  [N];
    logic [1:0] m_pend_k  [N];
    bit         m_valid;
    int         m_btn;
    logic [1:0] m_kind;
    bit         m_drop;
    int         m_rr;

    task automatic model_reset();
        for (int b = 0; b < N; b++) begin
            m_age[b]     = -1;
            m_blocked[b] = 1'b1;
            m_pipe_v[b]  = 1'b0;
            m_pipe_k[b]  = 2'd0;
            m_pend_v[b]  = 1'b0;
            m_pend_k[b]  = 2'd0;
        end
        m_valid = 1'b0;
        m_btn   = 0;
        m_kind  = 2'd0;
        m_drop  = 1'b0;
        m_rr    = 0;
    endtask

    task automatic model_step();
        bit         load;
        bit         drop;
        int         g;
        int         j;
        logic [1:0] out_k;
        if (!resetn) begin
            model_reset();
            return;
        end
        load = !m_valid || evt_ready;
        g = -1;
        for (int i = 0; i < N; i++) begin
            j = (m_rr + i) % N;
            if (g < 0 && m_pend_v[j]) g = j;
        end
        out_k = (g >= 0) ? m_pend_k[g] : 2'd0;
        drop = 1'b0;
        for (int b = 0; b < N; b++) begin
            if (m_pipe_v[b]) begin
                if (m_pend_v[b] && !(load && g == b)) begin
                    drop = 1'b1;
                end else begin
                    m_pend_v[b] = 1'b1;
                    m_pend_k[b] = m_pipe_k[b];
                end
            end else if (load && g == b) begin
                m_pend_v[b] = 1'b0;
            end
        end
        if (load) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_btn   = g;
                m_kind  = out_k;
                m_rr    = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        m_drop = drop;
        for (int b = 0; b < N; b++) begin
            m_pipe_v[b] = 1'b0;
            if (m_blocked[b]) begin
                if (!btn_level[b]) m_blocked[b] = 1'b0;
            end else if (btn_level[b]) begin
                if (m_age[b] < 0) begin
                    m_age[b]    = 0;
                    m_pipe_v[b] = 1'b1;
                    m_pipe_k[b] = 2'd0;
                end else begin
                    m_age[b]++;
                    if (m_age[b] == LONG) begin
                        m_pipe_v[b] = 1'b1;
                        m_pipe_k[b] = 2'd1;
                    end else if (m_age[b] > LONG && (m_age[b] - LONG) % RPT == 0) begin
                        m_pipe_v[b] = 1'b1;
                        m_pipe_k[b] = 2'd2;
                    end
                end
            end else begin
                m_age[b] = -1;
            end
        end
    endtask

    // ------------------------------------------------------------- driver
    // One clock: log a transfer happening at this edge, advance the model,
    // then compare DUT outputs against it 1 time unit after the edge.
    task automatic tick();
        if (evt_valid && evt_ready && resetn) begin
            ev_q.push_back('{c: cyc, b: int'(evt_btn), k: int'(evt_kind)});
        end
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        check("model_valid", int'(evt_valid), int'(m_valid));
        check("model_drop", int'(evt_drop), int'(m_drop));
        if (m_valid) begin
            check("model_btn", int'(evt_btn), m_btn);
            check("model_kind", int'(evt_kind), int'(m_kind));
        end
    endtask

    // ------------------------------------------------------ vector table
    typedef struct {
        logic [N-1:0] lvl;
        logic         rdy;
        logic         exp_v;
        logic [1:0]   exp_b;
        logic [1:0]   exp_k;
        logic         exp_d;
    } vec_t;

    localparam int NV = 16;
    vec_t vec [NV];

    int start_c;
    int drops;
    int waited;
    int t2_off  [4];
    int t2_kind [4];

    initial begin
        // T3 style: simultaneous presses, then btn1 alone moves rr to 2,
        // then simultaneous presses again start at btn2.
        vec[0]  = '{3'b111, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
        vec[1]  = '{3'b111, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
        vec[2]  = '{3'b111, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0};
        vec[3]  = '{3'b111, 1'b1, 1'b1, 2'd1, 2'd0, 1'b0};
        vec[4]  = '{3'b000, 1'b1, 1'b1, 2'd2, 2'd0, 1'b0};
        vec[5]  = '{3'b000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
        vec[6]  = '{3'b010, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
        vec[7]  = '{3'b000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
        vec[8]  = '{3'b000, 1'b1, 1'b1, 2'd1, 2'd0, 1'b0};
        vec[9]  = '{3'b000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
        vec[10] = '{3'b111, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
        vec[11] = '{3'b000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
        vec[12] = '{3'b000, 1'b1, 1'b1, 2'd2, 2'd0, 1'b0};
        vec[13] = '{3'b000, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0};
        vec[14] = '{3'b000, 1'b1, 1'b1, 2'd1, 2'd0, 1'b0};
        vec[15] = '{3'b000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};

        t2_off  = '{2, 18, 26, 34};
        t2_kind = '{0, 1, 2, 2};

        model_reset();
        resetn    = 1'b0;
        btn_level = '0;
        evt_ready = 1'b1;

        // ------------------------------------------------ reset state
        repeat (3) tick();
        check("reset_valid", int'(evt_valid), 0);
        check("reset_btn", int'(evt_btn), 0);
        check("reset_kind", int'(evt_kind), 0);
        check("reset_drop", int'(evt_drop), 0);
        resetn = 1'b1;
        repeat (2) tick();

        // ------------------------------------------------ table vectors
        for (int r = 0; r < NV; r++) begin
            btn_level = vec[r].lvl;
            evt_ready = vec[r].rdy;
            tick();
            check($sformatf("vec%0d_valid", r), int'(evt_valid), int'(vec[r].exp_v));
            check($sformatf("vec%0d_drop", r), int'(evt_drop), int'(vec[r].exp_d));
            if (vec[r].exp_v) begin
                check($sformatf("vec%0d_btn", r), int'(evt_btn), int'(vec[r].exp_b));
                check($sformatf("vec%0d_kind", r), int'(evt_kind), int'(vec[r].exp_k));
            end
        end

        // ------------------------------------------------ T1 short press
        ev_q.delete();
        start_c   = cyc + 1;
        btn_level = 3'b010;
        repeat (10) tick();
        btn_level = 3'b000;
        repeat (10) tick();
        check("t1_count", ev_q.size(), 1);
        if (ev_q.size() >= 1) begin
            check("t1_cycle", ev_q[0].c, start_c + 2);
            check("t1_btn", ev_q[0].b, 1);
            check("t1_kind", ev_q[0].k, 0);
        end

        // ------------------------------------------------ T2 long hold
        ev_q.delete();
        start_c   = cyc + 1;
        btn_level = 3'b001;
        repeat (40) tick();
        btn_level = 3'b000;
        repeat (15) tick();
        check("t2_count", ev_q.size(), 4);
        for (int i = 0; i < 4 && i < ev_q.size(); i++) begin
            check($sformatf("t2_cycle%0d", i), ev_q[i].c, start_c + t2_off[i]);
            check($sformatf("t2_kind%0d", i), ev_q[i].k, t2_kind[i]);
            check($sformatf("t2_btn%0d", i), ev_q[i].b, 0);
        end

        // ------------------------------------------------ T4 stall and drop
        ev_q.delete();
        drops     = 0;
        evt_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            btn_level = 3'b100;
            repeat (2) begin
                tick();
                if (evt_drop) drops++;
                if (evt_valid) begin
                    check("t4_hold_btn", int'(evt_btn), 2);
                    check("t4_hold_kind", int'(evt_kind), 0);
                end
            end
            btn_level = 3'b000;
            repeat (2) begin
                tick();
                if (evt_drop) drops++;
                if (evt_valid) begin
                    check("t4_hold_btn", int'(evt_btn), 2);
                    check("t4_hold_kind", int'(evt_kind), 0);
                end
            end
        end
        repeat (3) begin
            tick();
            if (evt_drop) drops++;
        end
        check("t4_drop_pulses", drops, 1);
        evt_ready = 1'b1;
        repeat (6) tick();
        check("t4_delivered", ev_q.size(), 2);
        for (int i = 0; i < ev_q.size(); i++) begin
            check($sformatf("t4_ev%0d_btn", i), ev_q[i].b, 2);
        end

        // ------------------------------------------------ T5 reset mid-event
        evt_ready = 1'b0;
        btn_level = 3'b001;
        waited    = 0;
        tick();
        while (!evt_valid && waited < 10) begin
            tick();
            waited++;
        end
        check("t5_valid_before_reset", int'(evt_valid), 1);
        resetn = 1'b0;
        tick();
        check("t5_reset_valid", int'(evt_valid), 0);
        check("t5_reset_btn", int'(evt_btn), 0);
        check("t5_reset_kind", int'(evt_kind), 0);
        resetn    = 1'b1;
        evt_ready = 1'b1;
        ev_q.delete();
        repeat (30) tick();
        check("t5_held_silent", ev_q.size(), 0);
        btn_level = 3'b000;
        repeat (2) tick();
        btn_level = 3'b001;
        repeat (3) tick();
        btn_level = 3'b000;
        repeat (5) tick();
        check("t5_repress_count", ev_q.size(), 1);
        if (ev_q.size() >= 1) begin
            check("t5_repress_btn", ev_q[0].b, 0);
            check("t5_repress_kind", ev_q[0].k, 0);
        end

        // ------------------------------------------------ T6 release at LONG-1
        ev_q.delete();
        btn_level = 3'b010;
        repeat (LONG) tick();
        btn_level = 3'b000;
        repeat (10) tick();
        check("t6_no_long_count", ev_q.size(), 1);

        // One cycle longer: the terminal count is reached while held.
        ev_q.delete();
        btn_level = 3'b010;
        repeat (LONG + 1) tick();
        btn_level = 3'b000;
        repeat (10) tick();
        check("t6_long_count", ev_q.size(), 2);
        if (ev_q.size() >= 2) begin
            check("t6_long_kind", ev_q[1].k, 1);
        end

        // ------------------------------------------------ random phase
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 19) == 0) btn_level[b] = ~btn_level[b];
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            resetn    = ($urandom_range(0, 599) != 0);
            tick();
        end
        resetn    = 1'b1;
        evt_ready = 1'b1;
        btn_level = '0;
        repeat (30) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
